// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle between the display-path controller and the BCD counter.
// Count width is 4*DIGITS, digit 0 in the low nibble.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 6
);
  logic                  tick;
  logic                  enable;
  logic                  up_down;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [4*DIGITS-1:0]   count;
  logic                  c_out;
  logic                  at_max;
  logic                  at_zero;
  logic                  load_err;

  modport master (
    output tick, enable, up_down, clear, load, data_in,
    input  count, c_out, at_max, at_zero, load_err
  );

  modport slave (
    input  tick, enable, up_down, clear, load, data_in,
    output count, c_out, at_max, at_zero, load_err
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, load, terminal value and wrap/saturate.
// Define BCD_COUNTER_LOAD_CHECK_EN to reject invalid loads and pulse load_err.
module bcd_updown_counter #(
  parameter int                  DIGITS   = 6,
  parameter logic [4*DIGITS-1:0] MAX_BCD  = {DIGITS{4'h9}},
  parameter bit                  SATURATE = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  bcd_updown_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] r_count;
  logic         r_c_out;
  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic [W-1:0] w_nib_clamp;
  logic [W-1:0] w_load_val;
  logic         w_step;
  logic         w_at_max;
  logic         w_at_zero;

  assign w_at_max  = (r_count == MAX_BCD);
  assign w_at_zero = (r_count == '0);
  assign w_step    = bus.enable && bus.tick;

  // Ripple carry/borrow across digits; the limits are handled in the register block.
  always_comb begin
    logic w_carry;
    logic w_borrow;
    w_inc    = '0;
    w_dec    = '0;
    w_carry  = 1'b1;
    w_borrow = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (!w_carry) begin
        w_inc[4*d +: 4] = r_count[4*d +: 4];
      end else if (r_count[4*d +: 4] == 4'd9) begin
        w_inc[4*d +: 4] = 4'd0;
      end else begin
        w_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
        w_carry         = 1'b0;
      end
      if (!w_borrow) begin
        w_dec[4*d +: 4] = r_count[4*d +: 4];
      end else if (r_count[4*d +: 4] == 4'd0) begin
        w_dec[4*d +: 4] = 4'd9;
      end else begin
        w_dec[4*d +: 4] = r_count[4*d +: 4] - 4'd1;
        w_borrow        = 1'b0;
      end
    end
  end

  always_comb begin
    w_nib_clamp = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_nib_clamp[4*d +: 4] = (bus.data_in[4*d +: 4] > 4'd9) ? 4'd9 : bus.data_in[4*d +: 4];
    end
  end

  // Valid BCD orders the same as binary, so a plain magnitude compare works.
  assign w_load_val = (w_nib_clamp > MAX_BCD) ? MAX_BCD : w_nib_clamp;

`ifdef BCD_COUNTER_LOAD_CHECK_EN
  logic w_load_bad;
  logic r_load_err;

  always_comb begin
    w_load_bad = (bus.data_in > MAX_BCD);
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.data_in[4*d +: 4] > 4'd9) w_load_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_load_err <= 1'b0;
    else     r_load_err <= !bus.clear && bus.load && w_load_bad;
  end

  assign bus.load_err = r_load_err;
`else
  logic w_load_bad;
  assign w_load_bad   = 1'b0;
  assign bus.load_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_c_out <= 1'b0;
    end else begin
      r_c_out <= 1'b0;
      if (bus.clear) begin
        r_count <= '0;
      end else if (bus.load) begin
        if (!w_load_bad) r_count <= w_load_val;
      end else if (w_step) begin
        if (bus.up_down) begin
          if (w_at_max) begin
            r_c_out <= 1'b1;
            if (!SATURATE) r_count <= '0;
          end else begin
            r_count <= w_inc;
          end
        end else begin
          if (w_at_zero) begin
            r_c_out <= 1'b1;
            if (!SATURATE) r_count <= MAX_BCD;
          end else begin
            r_count <= w_dec;
          end
        end
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.c_out   = r_c_out;
  assign bus.at_max  = w_at_max;
  assign bus.at_zero = w_at_zero;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: four counter configurations driven by shared controls,
// checked against a decimal-arithmetic reference model.
module tb_bcd_updown_counter;
  localparam int N = 4;

  typedef struct {
    int          due;
    int          id;
    logic [23:0] count;
    bit          c_out;
    bit          load_err;
    bit          at_max;
    bit          at_zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0, enable = 1'b0, up_down = 1'b0, clear = 1'b0, load = 1'b0;
  logic [23:0] din = '0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];

  // configurations: digits, decimal terminal value, saturate
  int m_digits[N] = '{2, 2, 2, 6};
  int m_max[N]    = '{99, 59, 59, 999999};
  bit m_sat[N]    = '{1'b0, 1'b0, 1'b1, 1'b0};
  int m_val[N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_updown_counter_if #(.DIGITS(2)) if0 ();
  bcd_updown_counter_if #(.DIGITS(2)) if1 ();
  bcd_updown_counter_if #(.DIGITS(2)) if2 ();
  bcd_updown_counter_if #(.DIGITS(6)) if3 ();

  assign if0.tick = tick; assign if0.enable = enable; assign if0.up_down = up_down;
  assign if0.clear = clear; assign if0.load = load; assign if0.data_in = din[7:0];
  assign if1.tick = tick; assign if1.enable = enable; assign if1.up_down = up_down;
  assign if1.clear = clear; assign if1.load = load; assign if1.data_in = din[7:0];
  assign if2.tick = tick; assign if2.enable = enable; assign if2.up_down = up_down;
  assign if2.clear = clear; assign if2.load = load; assign if2.data_in = din[7:0];
  assign if3.tick = tick; assign if3.enable = enable; assign if3.up_down = up_down;
  assign if3.clear = clear; assign if3.load = load; assign if3.data_in = din;

  bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h99), .SATURATE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h59), .SATURATE(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  bcd_updown_counter #(.DIGITS(2), .MAX_BCD(8'h59), .SATURATE(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  bcd_updown_counter #(.DIGITS(6)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  logic [23:0] o_cnt[N];
  logic        o_co[N], o_le[N], o_mx[N], o_zr[N];
  assign o_cnt[0] = {16'h0, if0.count}; assign o_co[0] = if0.c_out; assign o_le[0] = if0.load_err;
  assign o_mx[0] = if0.at_max; assign o_zr[0] = if0.at_zero;
  assign o_cnt[1] = {16'h0, if1.count}; assign o_co[1] = if1.c_out; assign o_le[1] = if1.load_err;
  assign o_mx[1] = if1.at_max; assign o_zr[1] = if1.at_zero;
  assign o_cnt[2] = {16'h0, if2.count}; assign o_co[2] = if2.c_out; assign o_le[2] = if2.load_err;
  assign o_mx[2] = if2.at_max; assign o_zr[2] = if2.at_zero;
  assign o_cnt[3] = if3.count; assign o_co[3] = if3.c_out; assign o_le[3] = if3.load_err;
  assign o_mx[3] = if3.at_max; assign o_zr[3] = if3.at_zero;

  function automatic logic [23:0] to_bcd(int v);
    logic [23:0] r;
    r = '0;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(string name, int id, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, id, cyc, got, exp);
    end
  endtask

  // Reference: value kept as a decimal integer, stepped with plain arithmetic.
  task automatic model(int i);
    exp_t e;
    int   v, dv, p;
    bit   bad;
    v = m_val[i];
    e.c_out = 1'b0;
    e.load_err = 1'b0;
    if (rst || clear) begin
      v = 0;
    end else if (load) begin
      dv = 0; p = 1; bad = 1'b0;
      for (int d = 0; d < m_digits[i]; d++) begin
        if (int'(din[4*d +: 4]) > 9) begin bad = 1'b1; dv += 9 * p; end
        else dv += int'(din[4*d +: 4]) * p;
        p *= 10;
      end
      if (dv > m_max[i]) begin bad = 1'b1; dv = m_max[i]; end
`ifdef BCD_COUNTER_LOAD_CHECK_EN
      if (bad) e.load_err = 1'b1;
      else v = dv;
`else
      v = dv;
`endif
    end else if (tick && enable) begin
      if (up_down) begin
        if (v == m_max[i]) begin e.c_out = 1'b1; if (!m_sat[i]) v = 0; end
        else v = v + 1;
      end else begin
        if (v == 0) begin e.c_out = 1'b1; if (!m_sat[i]) v = m_max[i]; end
        else v = v - 1;
      end
    end
    m_val[i]  = v;
    e.due     = cyc + 1;
    e.id      = i;
    e.count   = to_bcd(v);
    e.at_max  = (v == m_max[i]);
    e.at_zero = (v == 0);
    sb.push_back(e);
  endtask

  task automatic drive(bit r, bit c, bit l, bit t, bit en, bit ud, logic [23:0] d);
    @(posedge clk);
    #1;
    rst = r; clear = c; load = l; tick = t; enable = en; up_down = ud; din = d;
    for (int i = 0; i < N; i++) model(i);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic ticks(int n, bit ud);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ud, 24'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("count",    e.id, 32'(o_cnt[e.id]), 32'(e.count));
      chk("c_out",    e.id, 32'(o_co[e.id]),  32'(e.c_out));
      chk("load_err", e.id, 32'(o_le[e.id]),  32'(e.load_err));
      chk("at_max",   e.id, 32'(o_mx[e.id]),  32'(e.at_max));
      chk("at_zero",  e.id, 32'(o_zr[e.id]),  32'(e.at_zero));
    end
  end

  initial begin
    logic [23:0] rd;
    int          wait_cnt;
    for (int i = 0; i < N; i++) m_val[i] = 0;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0);
    ticks(12, 1'b1);
    idle();
    @(negedge clk);
    chk("plan_12_up", 0, 32'(if0.count), 32'h12);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000098);
    ticks(2, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    ticks(1, 1'b0);
    idle();
    @(negedge clk);
    chk("plan_wrap_down", 1, 32'(if1.count), 32'h59);
    chk("plan_sat_down",  2, 32'(if2.count), 32'h00);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000109);
    ticks(10, 1'b0);
    idle();
    @(negedge clk);
    chk("plan_borrow", 3, 32'(if3.count), 32'h000099);

    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000042);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000042);
    idle();
    @(negedge clk);
    chk("plan_load_over_tick", 0, 32'(if0.count), 32'h42);

    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00003A);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000055);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h999990);
    ticks(3, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000058);
    ticks(3, 1'b1);
    ticks(2, 1'b0);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        for (int d = 0; d < 6; d++) rd[4*d +: 4] = 4'($urandom_range(9, 0));
      end else begin
        rd = 24'($urandom);
      end
      drive($urandom_range(59, 0) == 0, $urandom_range(24, 0) == 0,
            $urandom_range(9, 0) == 0, $urandom_range(3, 0) != 0,
            $urandom_range(7, 0) != 0, $urandom_range(1, 0) == 1, rd);
    end
    idle();

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with synchronous clear, parallel load, programmable terminal value and wrap/saturate mode. Counts natively in BCD (one nibble per digit), so its output feeds the seven-segment display path directly without binary-to-BCD conversion. Sits between the clock-divider strobe and the display module, running on the system clock and advancing on a one-cycle `tick` enable rather than on a divided clock.

## Interface
Parameters:
- `DIGITS`, 6: number of BCD digits; count width is `4*DIGITS`.
- `MAX_BCD`, all digits 9 (24'h999999 at default): terminal value, BCD-encoded; every nibble is ≤ 9.
- `SATURATE`, 0: 0 selects wrap at the limits, 1 selects hold at the limits.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: one-cycle count strobe from the clock divider.
- `enable` input 1: count enable, qualifies `tick`.
- `up_down` input 1: 1 counts up, 0 counts down.
- `clear` input 1: synchronous clear to zero, single-cycle pulse expected.
- `load` input 1: parallel load of `data_in`.
- `data_in` input `4*DIGITS`: BCD load value, digit 0 in bits [3:0].
- `count` output `4*DIGITS`: registered BCD count.
- `c_out` output 1: registered one-cycle pulse on overflow or underflow event.
- `at_max` output 1: `count == MAX_BCD`, combinational from the register.
- `at_zero` output 1: `count == 0`, combinational from the register.
- `load_err` output 1: registered one-cycle pulse on a rejected load. Present only with `BCD_COUNTER_LOAD_CHECK_EN`. Tied to 0 otherwise.

## Operation
- Priority per cycle: `rst` > `clear` > `load` > count step (`enable && tick`). Only the highest-priority active action takes effect.
- `clear` and `load` act on any `clk` edge, independent of `tick` and `enable`.
- Count step, up: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit (ripple within one cycle).
- Up at `count == MAX_BCD`:
  - SATURATE=0: count goes to 0, `c_out`=1.
  - SATURATE=1: count holds, `c_out`=1.
- Count step, down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Down at `count == 0`:
  - SATURATE=0: count goes to `MAX_BCD`, `c_out`=1.
  - SATURATE=1: count holds, `c_out`=1.
- `c_out` is high for exactly the one cycle following the edge on which the limit event occurred. It is 0 on every other cycle, including cycles where `clear` or `load` pre-empt a step.
- `up_down` is sampled on the same edge as the step. Changing it between ticks is legal.
- Load sanitising without the macro:
  - Each nibble > 9 is clamped to 9.
  - The result is then clamped to `MAX_BCD` if it exceeds it.
  - The count therefore never holds an invalid value.

## Timing
- Reset values: `count`=0, `c_out`=0, `load_err`=0. Consequently `at_zero`=1, and `at_max`=1 only if `MAX_BCD`=0.
- Latency: one cycle from a qualifying input edge to `count`, `c_out` and `load_err`. `at_max` and `at_zero` follow `count` with zero additional latency.
- Back-to-back ticks on consecutive cycles each step the count. There is no minimum tick spacing.
- `rst` asserted during a tick, load or clear wins. The first step after release requires a new tick.
- `tick` with `enable`=0 is ignored, with no `c_out`.
- Simultaneous `clear` and `load`: clear wins.
- Simultaneous `load` and tick: load wins and the tick is lost.

## Configuration
- Macro `BCD_COUNTER_LOAD_CHECK_EN` defined:
  - A load is rejected if `data_in` has any nibble > 9 or if `data_in` > `MAX_BCD`.
  - On rejection, `count` holds and `load_err` pulses for one cycle.
  - Valid loads behave normally with `load_err`=0.
- Macro undefined:
  - No `load_err` register; the port is tied to 0.
  - Loads are clamped as described under Operation.

## Test plan
- Reset, then 12 ticks up, DIGITS=2, MAX_BCD=8'h99 -> `count`=8'h12, `c_out` never high, `at_zero` low after the first tick.
- Load 8'h98, two up ticks, SATURATE=0 -> `count` goes 8'h99 (`at_max`=1), then 8'h00 with a single-cycle `c_out` pulse.
- From 0, one down tick, MAX_BCD=8'h59:
  - SATURATE=0 -> `count`=8'h59, `c_out` pulse.
  - SATURATE=1 -> `count` stays 8'h00, `c_out` pulse.
- Load 24'h000109, one down tick, DIGITS=6 -> `count`=24'h000108. A further 9 down ticks -> 24'h000099, exercising the borrow chain.
- Same edge: `clear`, `load` (8'h42) and `tick` -> `count`=0. Next edge: `load` plus `tick` -> `count`=8'h42, no step applied.
- Load 8'h3A, MAX_BCD=8'h59:
  - Macro on -> `count` unchanged, `load_err` high for one cycle.
  - Macro off -> `count`=8'h39.
